axi_lite_regtest_master: RTL

Synthesizable, parametrised AXI4-Lite master for register self-test, used on-chip to qualify slave IP such as myImode. On start it writes a generated data pattern to C_NUM_REGS consecutive registers, reads each one back, checks responses and data, and reports pass/fail, error count and timeout. It supports two ordering modes and a per-handshake watchdog.

---
 rtl/axi_lite_regtest_pkg.sv | 17 +
 rtl/axi_lite_regtest_wdog.sv | 30 +++
 rtl/axi_lite_regtest_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regtest_pkg.sv
// Shared types and constants for the AXI4-Lite register self-test master.
package axi_lite_regtest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE_ST
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         ERR_W       = 8;

endpackage

// File: rtl/axi_lite_regtest_wdog.sv
// Per-state watchdog: counts cycles spent in the current state and flags
// expiry on the cycle that completes C_TIMEOUT cycles.
module axi_lite_regtest_wdog #(
    parameter int C_TIMEOUT = 255
) (
    input  logic clk,
    input  logic srst,
    input  logic clr_i,
    output logic expired_o
);

    localparam int            CW    = $clog2(C_TIMEOUT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(C_TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_d includes the current cycle, so the first cycle of a state counts as 1
    assign cnt_d     = clr_i ? CW'(1) : cnt_q + CW'(1);
    assign expired_o = (cnt_d >= LIMIT);

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= expired_o ? LIMIT : cnt_d;
        end
    end

endmodule

// File: rtl/axi_lite_regtest_master.sv
// AXI4-Lite master that writes a seeded pattern to consecutive registers,
// reads it back and reports pass/fail, error count and watchdog abort.
module axi_lite_regtest_master
    import axi_lite_regtest_pkg::*;
#(
    parameter int                      C_ADDR_WIDTH  = 32,
    parameter int                      C_DATA_WIDTH  = 32,
    parameter int                      C_NUM_REGS    = 4,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR   = '0,
    parameter logic [31:0]             C_PATTERN_INC = 32'h11111111,
    parameter int                      C_TIMEOUT     = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic                    mode,
    input  logic [C_DATA_WIDTH-1:0] seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [ERR_W-1:0]        err_count,
    output logic [C_ADDR_WIDTH-1:0] M_AWADDR,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [C_DATA_WIDTH-1:0] M_WDATA,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    output logic [C_ADDR_WIDTH-1:0] M_ARADDR,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [C_DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RVALID,
    output logic                    M_RREADY
);

    localparam logic [C_DATA_WIDTH-1:0] PAT_INC     = C_DATA_WIDTH'(C_PATTERN_INC);
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_STRIDE = C_ADDR_WIDTH'(C_DATA_WIDTH / 8);
    localparam logic [8:0]              LAST_IDX    = 9'(C_NUM_REGS - 1);
    localparam logic [ERR_W-1:0]        ERR_MAX     = {ERR_W{1'b1}};

    state_t                  state_q;
    state_t                  prev_q;
    logic [8:0]              idx_q;
    logic                    mode_q;
    logic [C_DATA_WIDTH-1:0] seed_q;
    logic [C_DATA_WIDTH-1:0] data_q;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    timeout_q;
    logic [ERR_W-1:0]        err_q;

    logic                    aw_fin;
    logic                    w_fin;
    logic                    bad_beat;
    logic [ERR_W-1:0]        err_d;
    logic                    last_idx;
    logic                    in_xfer;
    logic                    state_chg;
    logic                    wdog_expired;

    // A channel is finished once its VALID has dropped or is handshaking now
    assign aw_fin    = !awvalid_q || M_AWREADY;
    assign w_fin     = !wvalid_q  || M_WREADY;
    assign bad_beat  = (state_q == WR_RESP) ? (M_BRESP != RESP_OKAY)
                                            : ((M_RRESP != RESP_OKAY) || (M_RDATA != data_q));
    assign err_d     = (bad_beat && (err_q != ERR_MAX)) ? err_q + ERR_W'(1) : err_q;
    assign last_idx  = (idx_q == LAST_IDX);
    assign in_xfer   = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    assign state_chg = (state_q != prev_q);

    axi_lite_regtest_wdog #(
        .C_TIMEOUT(C_TIMEOUT)
    ) u_wdog (
        .clk      (ACLK),
        .srst     (ARESET),
        .clr_i    (state_chg),
        .expired_o(wdog_expired)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            prev_q    <= IDLE;
            idx_q     <= '0;
            mode_q    <= 1'b0;
            seed_q    <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
        end else begin
            prev_q <= state_q;
            done_q <= 1'b0;
            if (in_xfer && wdog_expired) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                timeout_q <= 1'b1;
                pass_q    <= 1'b0;
                done_q    <= 1'b1;
                state_q   <= DONE_ST;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            busy_q    <= 1'b1;
                            pass_q    <= 1'b0;
                            timeout_q <= 1'b0;
                            err_q     <= '0;
                            mode_q    <= mode;
                            seed_q    <= seed;
                            data_q    <= seed;
                            addr_q    <= C_BASE_ADDR;
                            idx_q     <= '0;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end
                    end
                    WR_REQ: begin
                        if (M_AWREADY) awvalid_q <= 1'b0;
                        if (M_WREADY)  wvalid_q  <= 1'b0;
                        if (aw_fin && w_fin) begin
                            bready_q <= 1'b1;
                            state_q  <= WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        if (M_BVALID) begin
                            bready_q <= 1'b0;
                            err_q    <= err_d;
                            if (!mode_q) begin
                                arvalid_q <= 1'b1;
                                state_q   <= RD_REQ;
                            end else if (last_idx) begin
                                // write phase complete: rewind to register 0 for reads
                                idx_q     <= '0;
                                addr_q    <= C_BASE_ADDR;
                                data_q    <= seed_q;
                                arvalid_q <= 1'b1;
                                state_q   <= RD_REQ;
                            end else begin
                                idx_q     <= idx_q + 9'd1;
                                addr_q    <= addr_q + ADDR_STRIDE;
                                data_q    <= data_q + PAT_INC;
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= WR_REQ;
                            end
                        end
                    end
                    RD_REQ: begin
                        if (M_ARREADY) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            state_q   <= RD_RESP;
                        end
                    end
                    RD_RESP: begin
                        if (M_RVALID) begin
                            rready_q <= 1'b0;
                            err_q    <= err_d;
                            if (last_idx) begin
                                pass_q  <= (err_d == '0);
                                done_q  <= 1'b1;
                                state_q <= DONE_ST;
                            end else begin
                                idx_q  <= idx_q + 9'd1;
                                addr_q <= addr_q + ADDR_STRIDE;
                                data_q <= data_q + PAT_INC;
                                if (!mode_q) begin
                                    awvalid_q <= 1'b1;
                                    wvalid_q  <= 1'b1;
                                    state_q   <= WR_REQ;
                                end else begin
                                    arvalid_q <= 1'b1;
                                    state_q   <= RD_REQ;
                                end
                            end
                        end
                    end
                    DONE_ST: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;
    assign M_AWADDR  = addr_q;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = data_q;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = bready_q;
    assign M_ARADDR  = addr_q;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = rready_q;

endmodule
